// File: rtl/popcount_sequencer.sv
// Multi-cycle population counter: one W-bit word is reduced 7 bits per cycle
// through a single shared 7-input adder tree, trading latency for area.

// 7-input popcount built from a carry-save tree of full adders.
module class4_adder (
    input  logic [6:0] in_bits,
    output logic [2:0] cnt
);

    logic s_a, c_a, s_b, c_b, s_c, c_c;

    // Two first-level full adders, one second-level on the sums, then the weight-2 carries are summed.
    always_comb begin
        s_a    = in_bits[0] ^ in_bits[1] ^ in_bits[2];
        c_a    = (in_bits[0] & in_bits[1]) | (in_bits[0] & in_bits[2]) | (in_bits[1] & in_bits[2]);
        s_b    = in_bits[3] ^ in_bits[4] ^ in_bits[5];
        c_b    = (in_bits[3] & in_bits[4]) | (in_bits[3] & in_bits[5]) | (in_bits[4] & in_bits[5]);
        s_c    = s_a ^ s_b ^ in_bits[6];
        c_c    = (s_a & s_b) | (s_a & in_bits[6]) | (s_b & in_bits[6]);
        cnt[0] = s_c;
        cnt[1] = c_a ^ c_b ^ c_c;
        cnt[2] = (c_a & c_b) | (c_a & c_c) | (c_b & c_c);
    end

endmodule

module popcount_sequencer #(
    parameter  int unsigned W     = 56,
    localparam int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int unsigned SLICE_W = 7;
    localparam int unsigned NSLICE  = W / SLICE_W;
    localparam int unsigned K_W     = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sh_q, sh_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [2:0]       slice_cnt;

    // The one shared adder tree always looks at the lowest slice of the shift register.
    class4_adder u_adder (
        .in_bits (sh_q[SLICE_W-1:0]),
        .cnt     (slice_cnt)
    );

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update: load in IDLE, one slice per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d    = in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + CNT_W'(slice_cnt);
                sh_d  = sh_q >> SLICE_W;
                k_d   = k_q + K_W'(1);
                if (k_q == K_W'(NSLICE - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags decode the state register only, so no input reaches an output combinationally.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_count = acc_q;

endmodule

// File: tb/tb_popcount_sequencer.sv
// Randomized and directed check of popcount_sequencer at W=56 and W=7.
module tb_popcount_sequencer;

    logic        clk;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [55:0] in_data;
    logic [5:0]  out_count;

    logic        in_valid7, in_ready7, out_valid7, out_ready7, busy7;
    logic [6:0]  in_data7;
    logic [2:0]  out_count7;

    popcount_sequencer #(.W(56)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    popcount_sequencer #(.W(7)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid7),
        .in_ready  (in_ready7),
        .in_data   (in_data7),
        .out_valid (out_valid7),
        .out_ready (out_ready7),
        .out_count (out_count7),
        .busy      (busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: number of set bits, independent of slicing order.
    function automatic int ref_pop(input logic [55:0] d);
        int n = 0;
        for (int i = 0; i < 56; i++) n += int'(d[i]);
        return n;
    endfunction

    // One word through the W=56 instance, optionally holding out_ready low for 'hold' DONE cycles.
    task automatic run_word(input string tag, input logic [55:0] d, input int hold);
        int lat;
        int held;
        lat = 0;
        while (!in_ready && lat < 50) begin tick(); lat++; end
        chk({tag, "_ready"}, int'(in_ready), 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_cnt"}, int'(out_count), ref_pop(d));
        chk({tag, "_busy"}, int'(busy), 1);
        held = int'(out_count);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_v"}, int'(out_valid), 1);
            chk({tag, "_hold_c"}, int'(out_count), held);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_post_v"}, int'(out_valid), 0);
        chk({tag, "_post_r"}, int'(in_ready), 1);
    endtask

    logic [55:0] words [6];
    logic [6:0]  words7 [16];

    initial begin
        int lat;
        int seen;
        int t_prev;
        int t_acc;
        logic [55:0] d;
        logic [55:0] d2;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid7  = 1'b0;
        in_data7   = '0;
        out_ready7 = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_count", int'(out_count), 0);
        rst = 1'b0;
        tick();

        // Directed patterns
        run_word("ones", {56{1'b1}}, 0);
        run_word("zeros", 56'h0, 0);
        run_word("alt", 56'hAA_AAAA_AAAA_AAAA, 0);
        run_word("ends", 56'h80_0000_0000_0001, 0);
        chk("ref_alt", ref_pop(56'hAA_AAAA_AAAA_AAAA), 28);

        // Random words, dense and sparse
        for (int i = 0; i < 20; i++) begin
            d = {24'($urandom), $urandom};
            if (i % 3 == 1) d = d & {24'($urandom), $urandom};
            if (i % 3 == 2) d = d | {24'($urandom), $urandom};
            run_word("rand", d, 0);
        end

        // Backpressure: 5 cycles with out_ready low in DONE
        run_word("bp", {24'($urandom), $urandom}, 5);

        // New word offered during RUN must be ignored
        d  = {24'($urandom), $urandom};
        d2 = ~d;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_data  = d2;
        tick();
        tick();
        chk("ign_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        chk("ign_lat", lat, 8);
        chk("ign_cnt", int'(out_count), ref_pop(d));
        tick();
        chk("ign_idle", int'(in_ready), 1);

        // Reset in RUN cycle 4
        in_valid = 1'b1;
        in_data  = {56{1'b1}};
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_count", int'(out_count), 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mrst_no_out", seen, 0);
        run_word("after_rst", 56'h12_3456_789A_BCDE, 0);

        // Back-to-back with in_valid held high: period NSLICE+2 = 10
        for (int i = 0; i < 6; i++) words[i] = {24'($urandom), $urandom};
        in_valid = 1'b1;
        in_data  = words[0];
        t_prev   = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            t_acc = cyc;
            if (i > 0) chk("b2b_period", t_acc - t_prev, 10);
            t_prev = t_acc;
            if (i < 5) in_data = words[i + 1];
            else in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 50) begin tick(); lat++; end
            chk("b2b_lat", lat, 8);
            chk("b2b_cnt", int'(out_count), ref_pop(words[i]));
            tick();
        end

        // Minimum width W=7: latency 1, period 3
        words7[0] = 7'h7F;
        words7[1] = 7'h00;
        for (int i = 2; i < 16; i++) words7[i] = 7'($urandom);
        in_valid7 = 1'b1;
        in_data7  = words7[0];
        t_prev    = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            t_acc = cyc;
            if (i > 0) chk("w7_period", t_acc - t_prev, 3);
            t_prev = t_acc;
            if (i < 15) in_data7 = words7[i + 1];
            else in_valid7 = 1'b0;
            lat = 0;
            while (!out_valid7 && lat < 20) begin tick(); lat++; end
            chk("w7_lat", lat, 1);
            chk("w7_cnt", int'(out_count7), ref_pop(56'(words7[i])));
            tick();
        end
        chk("w7_idle", int'(in_ready7), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
